pio_in_edge_capture: RTL

- Avalon-MM slave parallel input port: the input-direction counterpart of the existing output PIOs (segment/LED drivers). Used for pushbuttons and switches.
- Synchronises external pins into clk, optionally debounces them, and latches edges into a software-clearable capture register.
- Raises a level interrupt to the Nios II when an unmasked edge is captured.
- Sits in the system interconnect beside the output PIOs; software polls it or services its irq.

---
 rtl/pio_in_edge_capture.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pio_in_edge_capture.sv
// pio_in_edge_capture: Avalon-MM parallel input port for pushbuttons and switches.
// Synchronises WIDTH external pins into clk and exposes their settled value.
// Latches the selected edge type into a write-1-to-clear capture register.
// Raises a level irq while any captured bit is unmasked.
// Optional per-pin debounce filter: define PIO_IN_DEBOUNCE_EN.
// Register map: 0 data (RO), 1 direction (reads 0), 2 irq_mask (RW), 3 edge_capture (W1C).
module pio_in_edge_capture #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
  logic [WIDTH-1:0] sync_val;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_capture_reg;
  logic [WIDTH-1:0] edge_capture_next;
  logic [WIDTH-1:0] irq_mask_reg;
  logic [WIDTH-1:0] clear_mask;
  logic             wr_en;

  assign wr_en = chipselect & ~write_n;

  // Shift the raw pins through the synchroniser chain; stage 0 samples the pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_port};
    end
  end

  assign sync_val = sync_reg[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  // One filter per pin: a change is accepted only after it has persisted
  // DEBOUNCE_CYCLES consecutive clocks; any reversion restarts the count.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
    logic [CNT_W-1:0] cnt_reg;
    logic             stable_bit_reg;

    // Count consecutive cycles where the synchronised pin differs from the accepted value.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_reg        <= '0;
        stable_bit_reg <= 1'b0;
      end else if (sync_val[gi] == stable_bit_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_bit_reg <= sync_val[gi];
        cnt_reg        <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end

    assign stable[gi] = stable_bit_reg;
  end : g_debounce
`else
  // Without the filter the synchroniser output is taken as-is.
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign stable = sync_val;
`endif

  // Remember last cycle's settled value for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_reg <= '0;
    end else begin
      prev_reg <= stable;
    end
  end

  // Edge selection is fixed at elaboration time.
  if (EDGE_TYPE == 0) begin : g_edge_rise
    assign edge_det = stable & ~prev_reg;
  end else if (EDGE_TYPE == 1) begin : g_edge_fall
    assign edge_det = ~stable & prev_reg;
  end else begin : g_edge_any
    assign edge_det = stable ^ prev_reg;
  end

  // Software clear applies only to bits written as 1 at the capture address.
  always_comb begin
    clear_mask = '0;
    if (wr_en && (address == 2'd3)) begin
      clear_mask = writedata[WIDTH-1:0];
    end
    // A new edge is ORed in after the clear so it is never lost to a racing clear.
    edge_capture_next = (edge_capture_reg & ~clear_mask) | edge_det;
  end

  // Capture register and interrupt mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_capture_reg <= '0;
      irq_mask_reg     <= '0;
    end else begin
      edge_capture_reg <= edge_capture_next;
      if (wr_en && (address == 2'd2)) begin
        irq_mask_reg <= writedata[WIDTH-1:0];
      end
    end
  end

  // Only the low WIDTH bits of writedata carry meaning.
  if (WIDTH < 32) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = &{1'b0, writedata[31:WIDTH]};
  end

  // Zero-wait-state read mux; chipselect is not needed for reads.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = stable;
      2'd2:    readdata[WIDTH-1:0] = irq_mask_reg;
      2'd3:    readdata[WIDTH-1:0] = edge_capture_reg;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edge_capture_reg & irq_mask_reg);

endmodule
